fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 80 ++++++++
 tb/tb_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// fifo: single-clock FIFO with a registered read port.
// A write is accepted when en=1, rd_wr=1 and the FIFO is not full; a read is
// accepted when en=1, rd_wr=0 and the FIFO is not empty. Rejected operations
// leave every piece of state untouched, including dout.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_wr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic             empty,
   output logic             full,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_write;
   logic             do_read;

   // Status flags come only from the registered occupancy count, so they
   // cannot glitch on input activity.
   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);

   // rd_wr picks exactly one operation, so a write and a read are never
   // accepted in the same cycle. Reset blocks both, including the memory write.
   assign do_write = en & rd_wr & ~full & ~reset;
   assign do_read  = en & ~rd_wr & ~empty & ~reset;

   // Storage array; left uncleared on reset because the pointers make stale
   // entries unreachable until they are rewritten.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wptr] <= din;
      end
   end

   // Write pointer advances on every accepted write and wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
      end else if (do_write) begin
         wptr <= wptr + PTR_ONE;
      end
   end

   // Read pointer and the registered read data move together on an accepted read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rptr <= '0;
         dout <= '0;
      end else if (do_read) begin
         dout <= mem[rptr];
         rptr <= rptr + PTR_ONE;
      end
   end

   // Occupancy counter, 0..DEPTH, tracks accepted writes minus accepted reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (do_write) begin
         count <= count + CNT_ONE;
      end else if (do_read) begin
         count <= count - CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed plus randomized checks of fifo against a queue-based
// reference model of first-in-first-out behaviour.
module tb_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic             clk;
   logic             reset;
   logic             rd_wr;
   logic             en;
   logic [WIDTH-1:0] din;
   logic             empty;
   logic             full;
   logic [WIDTH-1:0] dout;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] model_dout;
   int               check_count;
   int               pass_count;
   int               fail_count;

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .rd_wr (rd_wr),
      .en    (en),
      .din   (din),
      .empty (empty),
      .full  (full),
      .dout  (dout)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and count the outcome.
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
      check_count++;
      assert (obs === exp) begin
         pass_count++;
      end else begin
         fail_count++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the reference model.
   task automatic checkState(input string tag);
      checkOutput({tag, ".empty"}, WIDTH'(empty), WIDTH'(model_q.size() == 0));
      checkOutput({tag, ".full"},  WIDTH'(full),  WIDTH'(model_q.size() == DEPTH));
      checkOutput({tag, ".dout"},  dout, model_dout);
   endtask

   // Drive one cycle of inputs, let the model take the same step, then check.
   task automatic applyStimulus(input string tag, input logic en_v,
                                input logic rd_wr_v, input logic [WIDTH-1:0] din_v);
      en    = en_v;
      rd_wr = rd_wr_v;
      din   = din_v;
      @(posedge clk);
      if (en_v) begin
         if (rd_wr_v) begin
            if (model_q.size() < DEPTH) model_q.push_back(din_v);
         end else begin
            if (model_q.size() > 0) model_dout = model_q.pop_front();
         end
      end
      #1;
      checkState(tag);
   endtask

   // Assert reset between clock edges and confirm it acts without a clock.
   task automatic asyncReset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_q.delete();
      model_dout = '0;
      checkState(tag);
      @(posedge clk);
      #1;
      checkState({tag, ".held"});
      reset = 1'b0;
   endtask

   logic [WIDTH-1:0] fill_words [8];
   logic [WIDTH-1:0] base;

   initial begin
      check_count = 0;
      pass_count  = 0;
      fail_count  = 0;
      fill_words  = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h8D, 8'h8D};

      // Reset with en=1 and a write pending: outputs settle without a clock edge.
      reset = 1'b1;
      en    = 1'b1;
      rd_wr = 1'b1;
      din   = 8'hFF;
      model_dout = '0;
      #2;
      checkState("reset_immediate");
      @(posedge clk);
      #1;
      checkState("reset_blocks_write");
      @(posedge clk);
      #1;
      reset = 1'b0;
      $display("[TB] reset released");

      // Fill to full with the fixed word list.
      for (int i = 0; i < 8; i++) applyStimulus("fill", 1'b1, 1'b1, fill_words[i]);

      // Keep writing while full; nothing may change.
      for (int i = 0; i < 75; i++) applyStimulus("overflow", 1'b1, 1'b1, WIDTH'($urandom));

      // Drain in order, then underflow reads must hold the last word.
      for (int i = 0; i < 8; i++) begin
         applyStimulus("drain", 1'b1, 1'b0, WIDTH'($urandom));
         checkOutput("drain_order", dout, fill_words[i]);
      end
      for (int i = 0; i < 17; i++) begin
         applyStimulus("underflow", 1'b1, 1'b0, WIDTH'($urandom));
         checkOutput("underflow_hold", dout, 8'h8D);
      end

      // Move the pointers off zero, then fill across the wrap and read back.
      for (int i = 0; i < 5; i++) applyStimulus("wrap_pre_wr", 1'b1, 1'b1, WIDTH'($urandom));
      for (int i = 0; i < 5; i++) applyStimulus("wrap_pre_rd", 1'b1, 1'b0, WIDTH'($urandom));
      base = WIDTH'($urandom);
      for (int i = 0; i < 8; i++) applyStimulus("wrap_wr", 1'b1, 1'b1, base + WIDTH'(i));
      for (int i = 0; i < 8; i++) begin
         applyStimulus("wrap_rd", 1'b1, 1'b0, WIDTH'($urandom));
         checkOutput("wrap_order", dout, base + WIDTH'(i));
      end

      // Reset with three words stored, then a fresh word must come out alone.
      for (int i = 0; i < 3; i++) applyStimulus("pre_reset_wr", 1'b1, 1'b1, WIDTH'($urandom));
      asyncReset("mid_reset");
      applyStimulus("post_reset_wr", 1'b1, 1'b1, 8'h5A);
      applyStimulus("post_reset_rd", 1'b1, 1'b0, 8'h00);
      checkOutput("post_reset_word", dout, 8'h5A);
      applyStimulus("post_reset_empty_rd", 1'b1, 1'b0, 8'h00);

      // Idle cycles with toggling rd_wr/din must not disturb stored data.
      applyStimulus("idle_pre_wr", 1'b1, 1'b1, 8'hC3);
      applyStimulus("idle_pre_wr", 1'b1, 1'b1, 8'h3C);
      for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b0, 1'(i), WIDTH'($urandom));
      applyStimulus("idle_post_rd", 1'b1, 1'b0, 8'h00);
      checkOutput("idle_word0", dout, 8'hC3);
      applyStimulus("idle_post_rd", 1'b1, 1'b0, 8'h00);
      checkOutput("idle_word1", dout, 8'h3C);

      // Randomized mix of reads, writes and idle cycles against the model.
      for (int i = 0; i < 300; i++) begin
         applyStimulus("random", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                       WIDTH'($urandom));
      end

      $display("[TB] stimulus complete, %0d failures", fail_count);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
